// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage: multi-cycle load/store with byte/half/word
// lanes, alignment faulting and a registered, sign- or zero-extended load result.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_valid,
    output logic        o_misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;

    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [1:0]    lat_size;
    logic          lat_unsigned;
    logic          lat_write;

    logic          request;
    logic          misaligned;
    logic          accept;
    logic          enter_done;

    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [1:0]    acc_size;
    logic          acc_unsigned;
    logic          acc_write;
    logic [AW-1:0] acc_idx;
    logic [3:0]    acc_mask;
    logic [31:0]   acc_lanes;

    logic [31:0]   mem [DEPTH_WORDS];

    // Upper address bits fold away: the array wraps modulo its size.
    logic          addr_unused;
    assign addr_unused = &{1'b0, i_addr[31:AW+2]};

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lo[0];
            2'd2:    return lo != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    return 4'b0001 << lo;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'd0:    return {4{wdata[7:0]}};
            2'd1:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[8*lo +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    return uns ? {24'd0, b} : 32'(b);
            2'd1:    return uns ? {16'd0, h} : 32'(h);
            default: return word;
        endcase
    endfunction

    assign request    = i_read_en | i_write_en;
    assign misaligned = is_misaligned(i_size, i_addr[1:0]);
    assign accept     = !rst && (state == IDLE) && request && !misaligned;

    // With LATENCY=1 the access happens on the accepting edge, so it uses the live inputs.
    assign acc_addr     = (state == IDLE) ? i_addr[AW+1:0] : lat_addr;
    assign acc_wdata    = (state == IDLE) ? i_wdata        : lat_wdata;
    assign acc_size     = (state == IDLE) ? i_size         : lat_size;
    assign acc_unsigned = (state == IDLE) ? i_unsigned     : lat_unsigned;
    assign acc_write    = (state == IDLE) ? i_write_en     : lat_write;
    assign acc_idx      = acc_addr[AW+1:2];
    assign acc_mask     = lane_mask(acc_size, acc_addr[1:0]);
    assign acc_lanes    = lane_data(acc_size, acc_wdata);

    assign enter_done   = !rst && (state != DONE) && (state_next == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy     = 1'b0;
        o_valid    = 1'b0;
        o_misalign = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    o_busy     = request && !misaligned;
                    o_misalign = request && misaligned;
                end
                WAIT:    o_busy  = 1'b1;
                DONE:    o_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 4'd0;
            lat_addr     <= '0;
            lat_wdata    <= 32'd0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_write    <= 1'b0;
        end else if (accept) begin
            cnt          <= 4'(LATENCY - 1);
            lat_addr     <= i_addr[AW+1:0];
            lat_wdata    <= i_wdata;
            lat_size     <= i_size;
            lat_unsigned <= i_unsigned;
            lat_write    <= i_write_en;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Array is deliberately not reset; only the completing edge touches it.
    always_ff @(posedge clk) begin
        if (enter_done && acc_write) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_mask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= 32'd0;
        end else if (enter_done && !acc_write) begin
            o_rdata <= load_extend(mem[acc_idx], acc_size, acc_addr[1:0], acc_unsigned);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table on a LATENCY=2 instance, hand-written
// reset-abort and LATENCY=1 back-to-back sequences.
module tb_dmem_responder;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        mis;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  size  [2];
    logic        uns   [2];
    logic [31:0] rdata [2];
    logic        busy  [2];
    logic        valid [2];
    logic        mis   [2];

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_rd [2];
    vec_t        vq [$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .i_read_en(rd[0]), .i_write_en(wr[0]), .i_addr(addr[0]), .i_wdata(wdata[0]),
        .i_size(size[0]), .i_unsigned(uns[0]),
        .o_rdata(rdata[0]), .o_busy(busy[0]), .o_valid(valid[0]), .o_misalign(mis[0])
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_read_en(rd[1]), .i_write_en(wr[1]), .i_addr(addr[1]), .i_wdata(wdata[1]),
        .i_size(size[1]), .i_unsigned(uns[1]),
        .o_rdata(rdata[1]), .o_busy(busy[1]), .o_valid(valid[1]), .o_misalign(mis[1])
    );

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] s, input logic u,
                                input logic m, input logic [31:0] e);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.size = s; v.uns = u; v.mis = m; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int w, input vec_t v);
        rd[w] = v.rd; wr[w] = v.wr; addr[w] = v.addr; wdata[w] = v.wdata;
        size[w] = v.size; uns[w] = v.uns;
    endtask

    task automatic idle_in(input int w);
        rd[w] = 1'b0; wr[w] = 1'b0; addr[w] = 32'd0; wdata[w] = 32'd0;
        size[w] = 2'd0; uns[w] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after a posedge; aligned requests are held through DONE.
    task automatic run_vec(input int w, input int lat, input vec_t v);
        logic [31:0] e;
        drive(w, v);
        if (v.mis) begin
            @(negedge clk);
            check("misalign_pulse", {31'd0, mis[w]}, 32'd1);
            check("misalign_busy", {31'd0, busy[w]}, 32'd0);
            check("misalign_valid", {31'd0, valid[w]}, 32'd0);
            step();
            idle_in(w);
            @(negedge clk);
            check("misalign_after", {31'd0, mis[w] | valid[w]}, 32'd0);
            check("misalign_rdata_hold", rdata[w], last_rd[w]);
            step();
        end else begin
            if (v.rd && !v.wr) exp_q.push_back(v.exp);
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                check("busy_cycle", {31'd0, busy[w]}, 32'd1);
                check("no_early_valid", {31'd0, valid[w] | mis[w]}, 32'd0);
                step();
            end
            @(negedge clk);
            check("valid_pulse", {31'd0, valid[w]}, 32'd1);
            check("done_not_busy", {31'd0, busy[w]}, 32'd0);
            if (v.rd && !v.wr) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("load_rdata", rdata[w], e);
                    last_rd[w] = e;
                end
            end else begin
                check("store_rdata_hold", rdata[w], last_rd[w]);
            end
            step();
        end
    endtask

    initial begin
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        idle_in(0);
        idle_in(1);

        //      rd  wr  addr          wdata         sz  u  mis exp
        vq.push_back(mk(0, 1, 32'h10,   32'hDEADBEEF, 2, 0, 0, 32'h0));
        vq.push_back(mk(1, 0, 32'h10,   32'h0,        2, 0, 0, 32'hDEADBEEF));
        vq.push_back(mk(1, 0, 32'h10,   32'h0,        2, 0, 0, 32'hDEADBEEF));
        vq.push_back(mk(0, 1, 32'h10,   32'h0,        2, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 32'h13,   32'h12345680, 0, 0, 0, 32'h0));
        vq.push_back(mk(1, 0, 32'h13,   32'h0,        0, 0, 0, 32'hFFFFFF80));
        vq.push_back(mk(1, 0, 32'h13,   32'h0,        0, 1, 0, 32'h00000080));
        vq.push_back(mk(1, 0, 32'h10,   32'h0,        2, 0, 0, 32'h80000000));
        vq.push_back(mk(1, 0, 32'h11,   32'h0,        1, 0, 1, 32'h0));
        vq.push_back(mk(1, 0, 32'h0,    32'h0,        3, 0, 1, 32'h0));
        vq.push_back(mk(0, 1, 32'h1000, 32'hA5A5A5A5, 2, 0, 0, 32'h0));
        vq.push_back(mk(1, 0, 32'h0,    32'h0,        2, 0, 0, 32'hA5A5A5A5));
        vq.push_back(mk(0, 1, 32'h20,   32'h11223344, 2, 0, 0, 32'h0));
        vq.push_back(mk(0, 1, 32'h22,   32'hABCD8001, 1, 0, 0, 32'h0));
        vq.push_back(mk(1, 0, 32'h22,   32'h0,        1, 0, 0, 32'hFFFF8001));
        vq.push_back(mk(1, 0, 32'h22,   32'h0,        1, 1, 0, 32'h00008001));
        vq.push_back(mk(1, 0, 32'h20,   32'h0,        1, 0, 0, 32'h00003344));
        vq.push_back(mk(1, 0, 32'h21,   32'h0,        0, 0, 0, 32'h00000033));
        vq.push_back(mk(1, 0, 32'h20,   32'h0,        2, 1, 0, 32'h80013344));
        vq.push_back(mk(0, 1, 32'h22,   32'hFFFFFFFF, 2, 0, 1, 32'h0));
        vq.push_back(mk(1, 0, 32'h20,   32'h0,        2, 0, 0, 32'h80013344));
        vq.push_back(mk(1, 1, 32'h24,   32'hCAFEF00D, 2, 0, 0, 32'h0));
        vq.push_back(mk(1, 0, 32'h24,   32'h0,        2, 0, 0, 32'hCAFEF00D));
        vq.push_back(mk(0, 1, 32'h25,   32'h0000005A, 0, 0, 0, 32'h0));
        vq.push_back(mk(1, 0, 32'h25,   32'h0,        0, 0, 0, 32'h0000005A));
        vq.push_back(mk(1, 0, 32'h27,   32'h0,        0, 1, 0, 32'h000000CA));
        vq.push_back(mk(1, 0, 32'h27,   32'h0,        0, 0, 0, 32'hFFFFFFCA));
        vq.push_back(mk(1, 0, 32'h24,   32'h0,        2, 0, 0, 32'hCAFE5A0D));
        vq.push_back(mk(0, 1, 32'h30,   32'h01020304, 2, 0, 0, 32'h0));
        vq.push_back(mk(1, 0, 32'h32,   32'h0,        1, 1, 0, 32'h00000102));

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_valid", {31'd0, valid[0]}, 32'd0);
        check("reset_misalign", {31'd0, mis[0]}, 32'd0);
        check("reset_rdata", rdata[0], 32'd0);
        check("reset_rdata_l1", rdata[1], 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", {31'd0, busy[0]}, 32'd0);
        check("post_reset_valid", {31'd0, valid[0]}, 32'd0);
        step();

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(0, 2, vq[i]);
        end
        idle_in(0);
        step();

        // Store aborted by reset while in WAIT: no write, no valid.
        drive(0, mk(0, 1, 32'h30, 32'hBADBAD00, 2, 0, 0, 32'h0));
        @(negedge clk);
        check("abort_busy0", {31'd0, busy[0]}, 32'd1);
        step();
        rst = 1'b1;
        idle_in(0);
        @(negedge clk);
        check("abort_rst_valid", {31'd0, valid[0]}, 32'd0);
        step();
        rst = 1'b0;
        last_rd[0] = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_valid", {31'd0, valid[0]}, 32'd0);
            check("abort_no_busy", {31'd0, busy[0]}, 32'd0);
            check("abort_rdata_reset", rdata[0], 32'd0);
            step();
        end
        run_vec(0, 2, mk(1, 0, 32'h30, 32'h0, 2, 0, 0, 32'h01020304));
        idle_in(0);
        step();

        // LATENCY=1: seed words, then back-to-back loads with the second held through DONE.
        run_vec(1, 1, mk(0, 1, 32'h0, 32'h11111111, 2, 0, 0, 32'h0));
        run_vec(1, 1, mk(0, 1, 32'h4, 32'h22222222, 2, 0, 0, 32'h0));
        idle_in(1);
        step();
        drive(1, mk(1, 0, 32'h0, 32'h0, 2, 0, 0, 32'h0));
        @(negedge clk);
        check("l1_c0_busy", {31'd0, busy[1]}, 32'd1);
        check("l1_c0_valid", {31'd0, valid[1]}, 32'd0);
        step();
        drive(1, mk(1, 0, 32'h4, 32'h0, 2, 0, 0, 32'h0));
        @(negedge clk);
        check("l1_c1_busy", {31'd0, busy[1]}, 32'd0);
        check("l1_c1_valid", {31'd0, valid[1]}, 32'd1);
        check("l1_c1_rdata", rdata[1], 32'h11111111);
        step();
        @(negedge clk);
        check("l1_c2_busy", {31'd0, busy[1]}, 32'd1);
        check("l1_c2_valid", {31'd0, valid[1]}, 32'd0);
        check("l1_c2_rdata", rdata[1], 32'h11111111);
        step();
        idle_in(1);
        @(negedge clk);
        check("l1_c3_busy", {31'd0, busy[1]}, 32'd0);
        check("l1_c3_valid", {31'd0, valid[1]}, 32'd1);
        check("l1_c3_rdata", rdata[1], 32'h22222222);
        step();
        @(negedge clk);
        check("l1_c4_idle", {31'd0, busy[1] | valid[1]}, 32'd0);
        check("l1_c4_rdata", rdata[1], 32'h22222222);
        step();

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
